seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector, next generation of the fixed 1101 detector.

---
 rtl/seq_det_pkg.sv | 55 +++++
 rtl/sat_counter.sv | 29 ++
 rtl/seq_detector_param.sv | 85 ++++++++
 tb/tb_seq_detector_param.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and elaboration-time KMP helpers for the pattern detector
package seq_det_pkg;

  localparam int MODE_MEALY  = 0;
  localparam int MODE_MOORE  = 1;
  localparam int MAX_PAT_LEN = 16;

  function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern, input int pos);
    return pattern[pos[3:0]];
  endfunction

  // Longest pattern prefix that is a suffix of (first 'state' pattern bits, din_bit).
  // The pattern is received MSB first, so prefix bit j is pattern[len-1-j].
  function automatic int border_next(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                     input int state, input logic din_bit);
    int   best;
    int   idx;
    logic match_ok;
    logic c;
    best = 0;
    for (int k = 1; k <= MAX_PAT_LEN; k++) begin
      if (k <= len && k <= state + 1) begin
        match_ok = 1'b1;
        for (int j = 0; j < MAX_PAT_LEN; j++) begin
          if (j < k) begin
            idx = state + 1 - k + j;
            c   = (idx == state) ? din_bit : pat_bit(pattern, len - 1 - idx);
            if (c != pat_bit(pattern, len - 1 - j)) match_ok = 1'b0;
          end
        end
        if (match_ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the whole pattern that is also its suffix.
  function automatic int full_border(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
    int   best;
    logic match_ok;
    best = 0;
    for (int k = 1; k < MAX_PAT_LEN; k++) begin
      if (k < len) begin
        match_ok = 1'b1;
        for (int j = 0; j < MAX_PAT_LEN; j++) begin
          if (j < k && pat_bit(pattern, len - 1 - j) != pat_bit(pattern, k - 1 - j))
            match_ok = 1'b0;
        end
        if (match_ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with sticky saturation flag and sync clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc && q != MAX) begin
      q <= q + 1'b1;
      if (q == MAX - 1'b1) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector, Mealy/Moore, overlap option
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 OVERLAP = 1,
  parameter int                 MOORE   = MODE_MEALY,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clear,
  output logic             dout,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int                     ST_W      = $clog2(PAT_LEN + 1);
  localparam logic [MAX_PAT_LEN-1:0] PAT_EXT   = MAX_PAT_LEN'(PATTERN);
  localparam logic [ST_W-1:0]        S_FULL    = ST_W'(PAT_LEN);
  localparam logic [ST_W-1:0]        S_RESTART =
    (OVERLAP != 0) ? ST_W'(full_border(PAT_EXT, PAT_LEN)) : '0;

  logic [ST_W-1:0] tab0 [PAT_LEN];
  logic [ST_W-1:0] tab1 [PAT_LEN];

  for (genvar i = 0; i < PAT_LEN; i++) begin : g_tab
    assign tab0[i] = ST_W'(border_next(PAT_EXT, PAT_LEN, i, 1'b0));
    assign tab1[i] = ST_W'(border_next(PAT_EXT, PAT_LEN, i, 1'b1));
  end

  logic [ST_W-1:0] s;
  logic [ST_W-1:0] s_eff;
  logic [ST_W-1:0] s_adv;
  logic [ST_W-1:0] s_next;
  logic            hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= '0;
    else        s <= s_next;
  end

  // Moore's full-match state behaves like the restart state for the next bit.
  always_comb begin
    s_eff  = s;
    s_adv  = '0;
    s_next = s;
    hit    = 1'b0;
    if (s == S_FULL) s_eff = S_RESTART;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (s_eff == ST_W'(i)) s_adv = din ? tab1[i] : tab0[i];
    end
    hit = en && (s_adv == S_FULL);
    if (en) begin
      if (MOORE == MODE_MOORE) s_next = s_adv;
      else                     s_next = hit ? S_RESTART : s_adv;
    end
  end

  if (MOORE == MODE_MOORE) begin : g_moore
    logic dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  dout_q <= 1'b0;
      else if (en) dout_q <= hit;
    end
    assign dout = dout_q;
  end else begin : g_mealy
    assign dout = hit;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hit),
    .clear(clear),
    .q    (match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench over several detector configurations
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic din = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  logic       d_mov, d_mno, d_moo, d_c2, d_p5, d_p1;
  logic [7:0] c_mov, c_mno, c_moo, c_p5, c_p1;
  logic [1:0] c_c2;
  logic       s_mov, s_mno, s_moo, s_c2, s_p5, s_p1;

  seq_detector_param u_mov (.clk(clk), .rst_n(rst_n), .en(en), .din(din), .clear(clear),
                            .dout(d_mov), .match_count(c_mov), .count_sat(s_mov));
  seq_detector_param #(.OVERLAP(0)) u_mno (.clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .clear(clear), .dout(d_mno), .match_count(c_mno), .count_sat(s_mno));
  seq_detector_param #(.MOORE(1)) u_moo (.clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .clear(clear), .dout(d_moo), .match_count(c_moo), .count_sat(s_moo));
  seq_detector_param #(.CNT_W(2)) u_c2 (.clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .clear(clear), .dout(d_c2), .match_count(c_c2), .count_sat(s_c2));
  seq_detector_param #(.PAT_LEN(5), .PATTERN(5'b10101)) u_p5 (.clk(clk), .rst_n(rst_n),
    .en(en), .din(din), .clear(clear), .dout(d_p5), .match_count(c_p5), .count_sat(s_p5));
  seq_detector_param #(.PAT_LEN(1), .PATTERN(1'b1)) u_p1 (.clk(clk), .rst_n(rst_n),
    .en(en), .din(din), .clear(clear), .dout(d_p1), .match_count(c_p1), .count_sat(s_p1));

  task automatic drive(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e; din = d; clear = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; din = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; din = 1'b1; clear = 1'b0;
    repeat (3) tick();
    tests++; if (c_p1 !== 8'd0) begin fails++; $display("FAIL reset_cnt_p1 got %0d exp 0", c_p1); end
    tests++; if (d_moo !== 1'b0) begin fails++; $display("FAIL reset_moore_dout got %b exp 0", d_moo); end
    tests++; if (c_mov !== 8'd0 || s_mov !== 1'b0) begin
      fails++; $display("FAIL reset_cnt_mov got %0d/%b exp 0/0", c_mov, s_mov); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (c_p1 !== 8'd1) begin fails++; $display("FAIL reset_release_p1 got %0d exp 1", c_p1); end
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [6:0] exp_ov;
    logic [6:0] exp_no;
    stream = 7'b1101101; exp_ov = 7'b0001001; exp_no = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0);
      tests++; if (d_mov !== exp_ov[i]) begin
        fails++; $display("FAIL mealy_ov_dout bit%0d got %b exp %b", 7 - i, d_mov, exp_ov[i]); end
      tests++; if (d_mno !== exp_no[i]) begin
        fails++; $display("FAIL mealy_nov_dout bit%0d got %b exp %b", 7 - i, d_mno, exp_no[i]); end
      tick();
      tests++; if (d_moo !== exp_ov[i]) begin
        fails++; $display("FAIL moore_dout bit%0d got %b exp %b", 7 - i, d_moo, exp_ov[i]); end
    end
    drive(1'b0, 1'b0, 1'b0);
    tests++; if (d_mov !== 1'b0) begin fails++; $display("FAIL mealy_en0_dout got %b exp 0", d_mov); end
    tick();
    tests++; if (d_moo !== 1'b1) begin fails++; $display("FAIL moore_hold got %b exp 1", d_moo); end
    tests++; if (c_mov !== 8'd2) begin fails++; $display("FAIL ov_count got %0d exp 2", c_mov); end
    tests++; if (c_mno !== 8'd1) begin fails++; $display("FAIL nov_count got %0d exp 1", c_mno); end
    tests++; if (c_moo !== 8'd2) begin fails++; $display("FAIL moore_count got %0d exp 2", c_moo); end
    tests++; if (c_p1 !== 8'd5) begin fails++; $display("FAIL len1_count got %0d exp 5", c_p1); end
    tests++; if (c_p5 !== 8'd0) begin fails++; $display("FAIL len5_nomatch got %0d exp 0", c_p5); end
  endtask

  task automatic test_repeat_ones();
    logic [5:0] stream;
    logic [5:0] exp_d;
    stream = 6'b111101; exp_d = 6'b000001;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0);
      tests++; if (d_mov !== exp_d[i]) begin
        fails++; $display("FAIL ones_dout bit%0d got %b exp %b", 6 - i, d_mov, exp_d[i]); end
      tick();
    end
    tests++; if (c_mov !== 8'd1) begin fails++; $display("FAIL ones_count got %0d exp 1", c_mov); end
  endtask

  task automatic test_moore_en_gap();
    do_reset();
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tests++; if (d_mov !== 1'b0) begin fails++; $display("FAIL gap_mealy_dout cyc%0d got %b exp 0", i, d_mov); end
      tick();
      tests++; if (d_moo !== 1'b0) begin fails++; $display("FAIL gap_moore_dout cyc%0d got %b exp 0", i, d_moo); end
    end
    drive(1'b1, 1'b1, 1'b0);
    tests++; if (d_mov !== 1'b1) begin fails++; $display("FAIL gap_mealy_match got %b exp 1", d_mov); end
    tick();
    tests++; if (d_moo !== 1'b1) begin fails++; $display("FAIL gap_moore_match got %b exp 1", d_moo); end
    tests++; if (c_moo !== 8'd1) begin fails++; $display("FAIL gap_moore_count got %0d exp 1", c_moo); end
    drive(1'b0, 1'b0, 1'b0); tick();
    tests++; if (d_moo !== 1'b1) begin fails++; $display("FAIL gap_moore_hold got %b exp 1", d_moo); end
    drive(1'b1, 1'b0, 1'b0); tick();
    tests++; if (d_moo !== 1'b0) begin fails++; $display("FAIL gap_moore_fall got %b exp 0", d_moo); end
  endtask

  task automatic test_reset_mid_and_clear();
    logic [6:0] stream;
    stream = 7'b1101101;
    do_reset();
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; din = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (d_mov !== 1'b0) begin fails++; $display("FAIL midreset_dout got %b exp 0", d_mov); end
    tick();
    tests++; if (c_mov !== 8'd0) begin fails++; $display("FAIL midreset_count got %0d exp 0", c_mov); end
    tests++; if (c_moo !== 8'd0) begin fails++; $display("FAIL midreset_moore got %0d exp 0", c_moo); end
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, stream[i], (i == 0));
      tick();
    end
    tests++; if (c_mov !== 8'd0 || s_mov !== 1'b0) begin
      fails++; $display("FAIL clear_on_match got %0d/%b exp 0/0", c_mov, s_mov); end
    tests++; if (c_mno !== 8'd0) begin fails++; $display("FAIL clear_nov got %0d exp 0", c_mno); end
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0);
    tests++; if (d_mov !== 1'b1) begin fails++; $display("FAIL clear_keeps_state got %b exp 1", d_mov); end
    tick();
    tests++; if (c_mov !== 8'd1) begin fails++; $display("FAIL post_clear_count got %0d exp 1", c_mov); end
  endtask

  task automatic test_saturation();
    logic [12:0] stream;
    int          exp_c [13];
    logic [12:0] exp_s;
    stream = 13'b1101101101101;
    exp_c  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    exp_s  = 13'b0000000001111;
    do_reset();
    for (int n = 0; n < 13; n++) begin
      drive(1'b1, stream[12 - n], 1'b0);
      tick();
      tests++; if (c_c2 !== 2'(exp_c[n]) || s_c2 !== exp_s[12 - n]) begin
        fails++; $display("FAIL sat_cnt bit%0d got %0d/%b exp %0d/%b", n + 1, c_c2, s_c2, exp_c[n], exp_s[12 - n]); end
    end
    tests++; if (c_mov !== 8'd4) begin fails++; $display("FAIL wide_count got %0d exp 4", c_mov); end
    drive(1'b0, 1'b0, 1'b1); tick();
    tests++; if (c_c2 !== 2'd0 || s_c2 !== 1'b0) begin
      fails++; $display("FAIL sat_clear got %0d/%b exp 0/0", c_c2, s_c2); end
    clear = 1'b0;
  endtask

  task automatic test_len5();
    logic [6:0] stream;
    logic [6:0] exp_d;
    stream = 7'b1010101; exp_d = 7'b0000101;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, stream[i], 1'b0);
      tests++; if (d_p5 !== exp_d[i]) begin
        fails++; $display("FAIL len5_dout bit%0d got %b exp %b", 7 - i, d_p5, exp_d[i]); end
      tick();
    end
    tests++; if (c_p5 !== 8'd2) begin fails++; $display("FAIL len5_count got %0d exp 2", c_p5); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_repeat_ones();
    test_moore_en_gap();
    test_reset_mid_and_clear();
    test_saturation();
    test_len5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
